uart_tx_serializer: RTL and testbench

- Byte-to-serial UART transmitter directly downstream of the FIFO-draining UART controller.
- Accepts one data word per single-cycle `uart_dv` strobe.
- Shifts the frame out on `uart_tx` as: start bit, LSB-first data, optional parity, stop bit(s).
- Pulses `uart_tx_done` for one cycle when the frame is complete; the controller waits on this pulse before fetching the next FIFO word.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx_serializer.sv | 138 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default link parameters and
// a width helper used by the TX (and later RX) paths.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg == TERM) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == TERM);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// then a one-cycle done pulse back to the FIFO-draining controller.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int UART_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_dv,
  input  logic [UART_DATA_WIDTH-1:0] uart_data,
  output logic                       uart_tx,
  output logic                       uart_tx_active,
  output logic                       uart_tx_done
);

  if (CLKS_PER_BIT < 2 || UART_DATA_WIDTH < 5 || UART_DATA_WIDTH > 9 ||
      (PARITY_EN != 0 && PARITY_EN != 1) || (PARITY_ODD != 0 && PARITY_ODD != 1) ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx_serializer: illegal parameter combination");
  end

  localparam int IW = idx_width(UART_DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_FLIP  = (PARITY_ODD != 0);

  uart_state_e                state_reg;
  logic [UART_DATA_WIDTH-1:0] shift_reg;
  logic [IW-1:0]              bit_idx_reg;
  logic                       stop_idx_reg;
  logic                       parity_reg;
  logic                       tx_reg;
  logic                       active_reg;
  logic                       done_reg;
  logic                       baud_clr;
  logic                       baud_tc;

  // The bit timer only runs while a line bit is being held.
  assign baud_clr = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (baud_clr),
    .tc   (baud_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      active_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (uart_dv) begin
            shift_reg    <= uart_data;
            parity_reg   <= (^uart_data) ^ ODD_FLIP;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b0;
            active_reg   <= 1'b1;
            state_reg    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tc) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            if (bit_idx_reg == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                tx_reg    <= parity_reg;
                state_reg <= ST_PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= ST_STOP;
              end
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (baud_tc) begin
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (baud_tc) begin
            if (stop_idx_reg == LAST_STOP) begin
              active_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end else begin
              stop_idx_reg <= stop_idx_reg + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          tx_reg     <= 1'b1;
          active_reg <= 1'b0;
          state_reg  <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx        = tx_reg;
  assign uart_tx_active = active_reg;
  assign uart_tx_done   = done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Drives four differently configured transmitters with the same strobes and
// compares {tx, active, done} every cycle against a frame-level reference.
module tb_uart_tx_serializer;

  localparam int CPB  = 4;
  localparam int LMAX = 48;
  localparam int PEN  [4] = '{0, 1, 1, 0};
  localparam int PODD [4] = '{0, 0, 1, 0};
  localparam int STOPS[4] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_dv;
  logic [7:0] uart_data;
  logic [3:0] tx_v, act_v, done_v;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .UART_DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .uart_dv(uart_dv), .uart_data(uart_data),
          .uart_tx(tx_v[0]), .uart_tx_active(act_v[0]), .uart_tx_done(done_v[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .UART_DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .uart_dv(uart_dv), .uart_data(uart_data),
          .uart_tx(tx_v[1]), .uart_tx_active(act_v[1]), .uart_tx_done(done_v[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .UART_DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut2 (.clk(clk), .rst_n(rst_n), .uart_dv(uart_dv), .uart_data(uart_data),
          .uart_tx(tx_v[2]), .uart_tx_active(act_v[2]), .uart_tx_done(done_v[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .UART_DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut3 (.clk(clk), .rst_n(rst_n), .uart_dv(uart_dv), .uart_data(uart_data),
          .uart_tx(tx_v[3]), .uart_tx_active(act_v[3]), .uart_tx_done(done_v[3]));

  // Expected {tx, active, done} in cycle t after the accepting edge (t=1 is the first start-bit cycle).
  function automatic logic [2:0] expect_line(input int k, input logic [7:0] d, input int t);
    int   nbits = 1 + 8 + PEN[k] + STOPS[k];
    int   len   = nbits * CPB;
    int   b;
    logic bitv;
    if (t > len + 1) return 3'b100;
    if (t == len + 1) return 3'b101;
    b = (t - 1) / CPB;
    if (b == 0)                      bitv = 1'b0;
    else if (b <= 8)                 bitv = d[b-1];
    else if (PEN[k] == 1 && b == 9)  bitv = (($countones(d) % 2) != PODD[k]);
    else                             bitv = 1'b1;
    return {bitv, 2'b10};
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed {tx,active,done}=%b expected %b", tag, obs, exp);
  endtask

  task automatic check_all(input string what, input logic [7:0] d, input int t);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s dut%0d data=%h t=%0d", what, k, d, t),
            {tx_v[k], act_v[k], done_v[k]}, expect_line(k, d, t));
  endtask

  // Call at a negedge with every DUT idle; returns at the negedge of the
  // cycle just after the longest frame's done pulse (its one idle cycle).
  task automatic run_frame(input logic [7:0] d, input int busy_a, input int busy_b,
                           input logic [7:0] busy_data);
    uart_dv   = 1'b1;
    uart_data = d;
    @(posedge clk);
    #1;
    uart_dv   = 1'b0;
    uart_data = 8'($urandom);
    for (int t = 1; t <= LMAX + 2; t++) begin
      @(negedge clk);
      check_all("frame", d, t);
      if (t == busy_a || t == busy_b) begin
        uart_dv   = 1'b1;
        uart_data = busy_data;
      end else begin
        uart_dv   = 1'b0;
        uart_data = 8'($urandom);
      end
    end
    $display("frame data=%h busy_at=%0d,%0d checks=%0d passed=%0d", d, busy_a, busy_b, total, pass_cnt);
  endtask

  initial begin
    int ba, bb;
    rst_n     = 1'b0;
    uart_dv   = 1'b0;
    uart_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 8'h00, 1000);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset_idle", 8'h00, 1000);

    run_frame(8'h55, 0, 0, 8'h00);
    run_frame(8'h07, 0, 0, 8'h00);
    run_frame(8'hFF, 0, 0, 8'h00);
    // Strobes mid-frame and during dut0's done cycle must be ignored.
    run_frame(8'hA5, 15, 41, 8'h00);

    // Reset during data bit 3 abandons every frame without a done pulse.
    uart_dv   = 1'b1;
    uart_data = 8'hC3;
    @(posedge clk);
    #1;
    uart_dv = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      check_all("pre_reset", 8'hC3, t);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all("mid_reset", 8'hC3, 1000);
    rst_n = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      check_all("after_reset", 8'hC3, 1000);
    end
    $display("mid-frame reset done checks=%0d passed=%0d", total, pass_cnt);
    run_frame(8'h3C, 0, 0, 8'h00);

    // Controller-style back-to-back words at the minimum gap.
    run_frame(8'h01, 0, 0, 8'h00);
    run_frame(8'h80, 0, 0, 8'h00);
    run_frame(8'hAA, 0, 0, 8'h00);
    run_frame(8'h00, 0, 0, 8'h00);

    for (int i = 0; i < 8; i++) begin
      ba = int'($urandom_range(41, 1));
      bb = ($urandom_range(1, 0) == 1) ? int'($urandom_range(41, 1)) : 0;
      run_frame(8'($urandom), ba, bb, 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
